// File: rtl/comparator_pkg.sv
// Shared types and width helpers for the serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  function automatic int unsigned num_digits(input int unsigned data_w, input int unsigned digit_w);
    return (digit_w == 0) ? 1 : data_w / digit_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned data_w, input int unsigned digit_w);
    return $clog2(num_digits(data_w, digit_w) + 1);
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one digit; equality is implied by neither flag set.
module digit_compare #(
  parameter int unsigned DIGIT_WIDTH = 1
) (
  input  logic [DIGIT_WIDTH-1:0] a,
  input  logic [DIGIT_WIDTH-1:0] b,
  output logic                   gt,
  output logic                   lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_comparator_nbits.sv
// Sequential MSB-first magnitude comparator, DIGIT_WIDTH bits per cycle, early exit on first
// differing digit, unsigned or two's-complement operands.
module serial_comparator_nbits
  import comparator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DIGIT_WIDTH = 1
) (
  input  logic                                              CLOCK_in,
  input  logic                                              RESET_in,
  input  logic                                              start_in,
  input  logic                                              signed_in,
  input  logic [DATA_WIDTH-1:0]                             A_in,
  input  logic [DATA_WIDTH-1:0]                             B_in,
  output logic                                              busy_out,
  output logic                                              done_out,
  output logic                                              AeqB,
  output logic                                              AgrtB,
  output logic                                              AlwrB,
  output logic [cnt_width(DATA_WIDTH, DIGIT_WIDTH)-1:0]     cycles_out
);

  localparam int unsigned NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int unsigned CNT_W      = cnt_width(DATA_WIDTH, DIGIT_WIDTH);

  if (DIGIT_WIDTH < 1) begin : g_bad_digit
    $error("serial_comparator_nbits: DIGIT_WIDTH must be at least 1");
  end else if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_ratio
    $error("serial_comparator_nbits: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic                   sgn_q, sgn_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;

  logic [DIGIT_WIDTH-1:0] dig_a, dig_b;
  logic                   dig_gt, dig_lt;

  // Flipping both sign bits on the first digit maps two's complement onto offset binary.
  always_comb begin
    dig_a = a_q[DATA_WIDTH-1 -: DIGIT_WIDTH];
    dig_b = b_q[DATA_WIDTH-1 -: DIGIT_WIDTH];
    if (sgn_q && (cnt_q == '0)) begin
      dig_a[DIGIT_WIDTH-1] = ~dig_a[DIGIT_WIDTH-1];
      dig_b[DIGIT_WIDTH-1] = ~dig_b[DIGIT_WIDTH-1];
    end
  end

  digit_compare #(.DIGIT_WIDTH(DIGIT_WIDTH)) u_digit_compare (
    .a  (dig_a),
    .b  (dig_b),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    cycles_d = cycles_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = A_in;
          b_d     = B_in;
          sgn_d   = signed_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (dig_gt || dig_lt) begin
          eq_d     = 1'b0;
          gt_d     = dig_gt;
          lt_d     = dig_lt;
          cycles_d = cnt_q + CNT_W'(1);
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          eq_d     = 1'b1;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          cycles_d = CNT_W'(NUM_DIGITS);
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          a_d   = a_q << DIGIT_WIDTH;
          b_d   = b_q << DIGIT_WIDTH;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_in or posedge RESET_in) begin
    if (RESET_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign AeqB       = eq_q;
  assign AgrtB      = gt_q;
  assign AlwrB      = lt_q;
  assign cycles_out = cycles_q;

endmodule

// File: tb/tb_serial_comparator_nbits.sv
// Scoreboard bench for serial_comparator_nbits: one DUT with 1-bit digits, one with 4-bit digits.
module tb_serial_comparator_nbits;

  typedef struct {
    logic [2:0] flags;     // {eq, gt, lt}
    int         k;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       st1, sg1, busy1, done1, eq1, gt1, lt1;
  logic [7:0] a1, b1;
  logic [3:0] cy1;
  logic       st4, sg4, busy4, done4, eq4, gt4, lt4;
  logic [7:0] a4, b4;
  logic [1:0] cy4;

  serial_comparator_nbits #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_dut1 (
    .CLOCK_in(clk), .RESET_in(rst), .start_in(st1), .signed_in(sg1),
    .A_in(a1), .B_in(b1), .busy_out(busy1), .done_out(done1),
    .AeqB(eq1), .AgrtB(gt1), .AlwrB(lt1), .cycles_out(cy1)
  );

  serial_comparator_nbits #(.DATA_WIDTH(8), .DIGIT_WIDTH(4)) u_dut4 (
    .CLOCK_in(clk), .RESET_in(rst), .start_in(st4), .signed_in(sg4),
    .A_in(a4), .B_in(b4), .busy_out(busy4), .done_out(done4),
    .AeqB(eq4), .AgrtB(gt4), .AlwrB(lt4), .cycles_out(cy4)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input int dw);
    exp_t e;
    bit   found = 1'b0;
    e.k        = 8 / dw;
    e.done_cyc = 0;
    for (int p = 7; p >= 0; p--) begin
      if (!found && (a[p] != b[p])) begin
        found = 1'b1;
        e.k   = (7 - p) / dw + 1;
      end
    end
    if (s) e.flags = {a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
    else   e.flags = {a == b, a > b, a < b};
    return e;
  endfunction

  // Each done pulse must match the oldest outstanding request in flags, count and timing.
  always @(posedge clk) begin
    #1;
    if (done1) begin
      if (q1.size() == 0) check("d1_spurious_done", 32'(done1), 32'd0);
      else begin
        m1 = q1.pop_front();
        check("d1_flags", 32'({eq1, gt1, lt1}), 32'(m1.flags));
        check("d1_cycles", 32'(cy1), 32'(m1.k));
        check("d1_latency", 32'(cyc), 32'(m1.done_cyc));
      end
    end else if (q1.size() > 0 && cyc >= q1[0].done_cyc) begin
      check("d1_done_missing", 32'(done1), 32'd1);
      void'(q1.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (done4) begin
      if (q4.size() == 0) check("d4_spurious_done", 32'(done4), 32'd0);
      else begin
        m4 = q4.pop_front();
        check("d4_flags", 32'({eq4, gt4, lt4}), 32'(m4.flags));
        check("d4_cycles", 32'(cy4), 32'(m4.k));
        check("d4_latency", 32'(cyc), 32'(m4.done_cyc));
      end
    end else if (q4.size() > 0 && cyc >= q4[0].done_cyc) begin
      check("d4_done_missing", 32'(done4), 32'd1);
      void'(q4.pop_front());
    end
  end

  // Called at a negedge with the DUT idle; returns at the following negedge (SCAN).
  task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    a1 = a; b1 = b; sg1 = s; st1 = 1'b1;
    e = model(a, b, s, 1);
    e.done_cyc = cyc + 1 + e.k;
    q1.push_back(e);
    @(negedge clk);
    st1 = 1'b0;
    check("d1_busy_scan", 32'(busy1), 32'd1);
  endtask

  task automatic start4(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    a4 = a; b4 = b; sg4 = s; st4 = 1'b1;
    e = model(a, b, s, 4);
    e.done_cyc = cyc + 1 + e.k;
    q4.push_back(e);
    @(negedge clk);
    st4 = 1'b0;
    check("d4_busy_scan", 32'(busy4), 32'd1);
  endtask

  task automatic wait1();
    for (int i = 0; i < 20 && q1.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("d1_busy_idle", 32'(busy1), 32'd0);
  endtask

  task automatic wait4();
    for (int i = 0; i < 20 && q4.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("d4_busy_idle", 32'(busy4), 32'd0);
  endtask

  // Asserts reset between clock edges and expects every output cleared before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    q1.delete();
    q4.delete();
    #1;
    check({tag, "_out1"}, 32'({busy1, done1, eq1, gt1, lt1, cy1}), 32'd0);
    check({tag, "_out4"}, 32'({busy4, done4, eq4, gt4, lt4, cy4}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t       e;
    logic [7:0] ra, rb;
    logic       rs;
    rst = 1'b1;
    st1 = 1'b0; sg1 = 1'b0; a1 = '0; b1 = '0;
    st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
    @(negedge clk);
    check("reset_out1", 32'({busy1, done1, eq1, gt1, lt1, cy1}), 32'd0);
    check("reset_out4", 32'({busy4, done4, eq4, gt4, lt4, cy4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start1(8'hA5, 8'h25, 1'b0); wait1();
    start1(8'h3C, 8'h3C, 1'b0); wait1();
    start1(8'h3C, 8'h3D, 1'b0); wait1();
    start1(8'h80, 8'h01, 1'b1); wait1();
    start1(8'h80, 8'h01, 1'b0); wait1();
    start1(8'hFF, 8'hFE, 1'b1); wait1();

    async_reset("rst_idle");
    start1(8'h3C, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    async_reset("rst_scan");
    start1(8'h12, 8'h34, 1'b0); wait1();

    // A start pulse while scanning must not disturb the running compare.
    start1(8'h10, 8'h20, 1'b0);
    a1 = 8'hFF; b1 = 8'h00; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    wait1();
    check("d1_after_ignored", 32'({eq1, gt1, lt1}), 32'b001);
    repeat (4) @(negedge clk);
    check("d1_flags_hold", 32'({eq1, gt1, lt1}), 32'b001);
    start1(8'h90, 8'h10, 1'b0);
    check("d1_flags_not_cleared", 32'({eq1, gt1, lt1}), 32'b001);
    wait1();

    start4(8'h5A, 8'h5B, 1'b0); wait4();

    // Start held high: a new compare is accepted every NUM_DIGITS+2 cycles here (k=2).
    a4 = 8'h5A; b4 = 8'h5B; sg4 = 1'b0; st4 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      e = model(8'h5A, 8'h5B, 1'b0, 4);
      e.done_cyc = cyc + 1 + 2 + 4 * j;
      q4.push_back(e);
    end
    repeat (12) @(negedge clk);
    st4 = 1'b0;
    wait4();

    start4(8'h80, 8'h7F, 1'b1); wait4();
    start4(8'hC3, 8'hC3, 1'b1); wait4();

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      start1(ra, rb, rs); wait1();
      start4(rb, ra, ~rs); wait4();
    end

    check("d1_queue_empty", 32'(q1.size()), 32'd0);
    check("d4_queue_empty", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
